// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the FU/MAU memory port arbiter.
// State codes, owner codes, access lengths and the muxed command bundle.
package mem_port_arbiter_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_HOLD = 2'd1,
      ARB_WAIT = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_FU  = 1'b0,
      OWN_MAU = 1'b1
   } owner_e;

   localparam logic [1:0] MEM_LEN_B = 2'd0;
   localparam logic [1:0] MEM_LEN_H = 2'd1;
   localparam logic [1:0] MEM_LEN_W = 2'd2;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [1:0]      len;
   } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between Fetch Unit and Memory Access Unit.
// Ports: clk/rstn; i_fu_* / o_fu_* fetch side; i_mau_* / o_mau_* load-store side;
//        o_mem_* / i_mem_* memory wrapper side. One transaction outstanding.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int IF_MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            i_fu_req,
   input  logic [XLEN-1:0] i_fu_addr,
   input  logic            i_fu_flush,
   output logic            o_fu_gnt,
   output logic            o_fu_rvalid,
   output logic [XLEN-1:0] o_fu_rdata,
   input  logic            i_mau_req,
   input  logic            i_mau_we,
   input  logic [XLEN-1:0] i_mau_addr,
   input  logic [XLEN-1:0] i_mau_wdata,
   input  logic [1:0]      i_mau_len,
   output logic            o_mau_gnt,
   output logic            o_mau_rvalid,
   output logic [XLEN-1:0] o_mau_rdata,
   output logic            o_mem_req,
   output logic            o_mem_we,
   output logic [XLEN-1:0] o_mem_addr,
   output logic [XLEN-1:0] o_mem_wdata,
   output logic [1:0]      o_mem_len,
   input  logic            i_mem_gnt,
   input  logic            i_mem_rvalid,
   input  logic [XLEN-1:0] i_mem_rdata
);

   localparam int CW = $clog2(IF_MAX_WAIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = CW'(IF_MAX_WAIT);

   arb_state_e    state_q, state_d;
   owner_e        owner_q, owner_d;
   logic [CW-1:0] starve_q, starve_d;
   logic          drop_q, drop_d;

   owner_e   sel_own;
   logic     req;
   logic     fu_elig;
   logic     fu_gnt, mau_gnt;
   logic     fu_rv, mau_rv;
   mem_cmd_t fu_cmd, mau_cmd, cmd;

   assign fu_cmd  = '{we: 1'b0, addr: i_fu_addr,
                      wdata: '0, len: MEM_LEN_W};
   assign mau_cmd = '{we: i_mau_we, addr: i_mau_addr,
                      wdata: i_mau_wdata, len: i_mau_len};

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      drop_d  = drop_q;
      sel_own = owner_q;
      req     = 1'b0;
      fu_rv   = 1'b0;
      mau_rv  = 1'b0;
      fu_elig = i_fu_req & ~i_fu_flush;
      unique case (state_q)
         ARB_IDLE: begin
            if (starve_q == STARVE_MAX && fu_elig) begin
               req     = 1'b1;
               sel_own = OWN_FU;
            end else if (i_mau_req) begin
               req     = 1'b1;
               sel_own = OWN_MAU;
            end else if (fu_elig) begin
               req     = 1'b1;
               sel_own = OWN_FU;
            end
            if (req) begin
               owner_d = sel_own;
               state_d = i_mem_gnt ? ARB_WAIT : ARB_HOLD;
            end
         end
         ARB_HOLD: begin
            // Request stays up even across a flush; only the response is dropped.
            req = 1'b1;
            if (owner_q == OWN_FU && i_fu_flush) drop_d = 1'b1;
            if (i_mem_gnt) state_d = ARB_WAIT;
         end
         ARB_WAIT: begin
            if (owner_q == OWN_FU && i_fu_flush) drop_d = 1'b1;
            if (i_mem_rvalid) begin
               state_d = ARB_IDLE;
               drop_d  = 1'b0;
               fu_rv   = (owner_q == OWN_FU) & ~drop_q & ~i_fu_flush;
               mau_rv  = (owner_q == OWN_MAU);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign cmd     = (sel_own == OWN_FU) ? fu_cmd : mau_cmd;
   assign fu_gnt  = req & i_mem_gnt & (sel_own == OWN_FU);
   assign mau_gnt = req & i_mem_gnt & (sel_own == OWN_MAU);

   // Counts MAU wins while FU waits; any idle-FU cycle clears it.
   always_comb begin
      starve_d = starve_q;
      if (!i_fu_req) begin
         starve_d = '0;
      end else if (fu_gnt) begin
         starve_d = '0;
      end else if (mau_gnt && starve_q != STARVE_MAX) begin
         starve_d = starve_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ARB_IDLE;
         owner_q  <= OWN_FU;
         starve_q <= '0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
         drop_q   <= drop_d;
      end
   end

   // Outputs are forced quiet while reset is held, even though IDLE
   // selection is combinational on the request inputs.
   assign o_mem_req    = rstn & req;
   assign o_mem_we     = rstn & req & cmd.we;
   assign o_mem_addr   = (rstn && req) ? cmd.addr  : '0;
   assign o_mem_wdata  = (rstn && req) ? cmd.wdata : '0;
   assign o_mem_len    = (rstn && req) ? cmd.len   : '0;
   assign o_fu_gnt     = rstn & fu_gnt;
   assign o_mau_gnt    = rstn & mau_gnt;
   assign o_fu_rvalid  = rstn & fu_rv;
   assign o_mau_rvalid = rstn & mau_rv;
   assign o_fu_rdata   = (rstn && fu_rv)  ? i_mem_rdata : '0;
   assign o_mau_rdata  = (rstn && mau_rv) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a latency-programmable memory.
// Directed stimulus pushes expected grants/responses; a monitor pops them.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic            i_fu_req, i_fu_flush;
   logic [31:0]     i_fu_addr;
   logic            o_fu_gnt, o_fu_rvalid;
   logic [31:0]     o_fu_rdata;
   logic            i_mau_req, i_mau_we;
   logic [31:0]     i_mau_addr, i_mau_wdata;
   logic [1:0]      i_mau_len;
   logic            o_mau_gnt, o_mau_rvalid;
   logic [31:0]     o_mau_rdata;
   logic            o_mem_req, o_mem_we;
   logic [31:0]     o_mem_addr, o_mem_wdata;
   logic [1:0]      o_mem_len;
   logic            i_mem_gnt, i_mem_rvalid;
   logic [31:0]     i_mem_rdata;

   mem_port_arbiter #(.IF_MAX_WAIT(4)) dut (
      .clk(clk), .rstn(rstn),
      .i_fu_req(i_fu_req), .i_fu_addr(i_fu_addr),
      .i_fu_flush(i_fu_flush), .o_fu_gnt(o_fu_gnt),
      .o_fu_rvalid(o_fu_rvalid), .o_fu_rdata(o_fu_rdata),
      .i_mau_req(i_mau_req), .i_mau_we(i_mau_we),
      .i_mau_addr(i_mau_addr), .i_mau_wdata(i_mau_wdata),
      .i_mau_len(i_mau_len), .o_mau_gnt(o_mau_gnt),
      .o_mau_rvalid(o_mau_rvalid), .o_mau_rdata(o_mau_rdata),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .o_mem_len(o_mem_len), .i_mem_gnt(i_mem_gnt),
      .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
   );

   typedef struct {
      logic        fu;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  len;
   } gexp_t;

   typedef struct {
      logic        fu;
      logic        chk_data;
      logic [31:0] data;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];
   gexp_t gm;
   rexp_t rm;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int gnt_seen = 0;
   int last_gnt_cyc = 0;
   int last_rsp_cyc = 0;
   int lat = 2;

   logic [31:0] mem [logic [31:0]];
   logic        pend = 1'b0;
   int          pcnt = 0;
   logic [31:0] pdata = '0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory model: accepts on req&gnt, answers lat cycles later.
   initial begin
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            pend = 1'b0;
         end else if (o_mem_req && i_mem_gnt) begin
            pend = 1'b1;
            pcnt = lat;
            if (o_mem_we) begin
               mem[o_mem_addr] = o_mem_wdata;
               pdata = '0;
            end else begin
               pdata = mem.exists(o_mem_addr) ? mem[o_mem_addr] : '0;
            end
         end
         @(posedge clk);
         #1;
         i_mem_rvalid = 1'b0;
         i_mem_rdata  = '0;
         if (pend && rstn) begin
            if (pcnt <= 1) begin
               i_mem_rvalid = 1'b1;
               i_mem_rdata  = pdata;
               pend = 1'b0;
            end else begin
               pcnt--;
            end
         end
      end
   end

   // Monitor: pops expectations whenever the DUT grants or responds.
   initial forever begin
      @(negedge clk);
      if (rstn) begin
         if (o_mem_req && i_mem_gnt) begin
            gnt_seen++;
            last_gnt_cyc = cyc;
            checks++;
            if (gq.size() == 0) begin
               errors++;
               $display("FAIL grant_unexpected fu=%0b mau=%0b addr=%h",
                        o_fu_gnt, o_mau_gnt, o_mem_addr);
            end else begin
               gm = gq.pop_front();
               if (o_fu_gnt !== gm.fu || o_mau_gnt !== ~gm.fu ||
                   o_mem_we !== gm.we || o_mem_addr !== gm.addr ||
                   o_mem_wdata !== gm.wdata || o_mem_len !== gm.len) begin
                  errors++;
                  $display("FAIL grant actual fu=%0b mau=%0b we=%0b a=%h wd=%h len=%0d required fu=%0b we=%0b a=%h wd=%h len=%0d",
                           o_fu_gnt, o_mau_gnt, o_mem_we, o_mem_addr,
                           o_mem_wdata, o_mem_len, gm.fu, gm.we,
                           gm.addr, gm.wdata, gm.len);
               end
            end
         end
         if (o_fu_rvalid || o_mau_rvalid) begin
            last_rsp_cyc = cyc;
            checks++;
            if (rq.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected fu_rv=%0b mau_rv=%0b",
                        o_fu_rvalid, o_mau_rvalid);
            end else begin
               rm = rq.pop_front();
               if (o_fu_rvalid !== rm.fu || o_mau_rvalid !== ~rm.fu ||
                   (rm.chk_data && rm.fu && o_fu_rdata !== rm.data) ||
                   (rm.chk_data && !rm.fu && o_mau_rdata !== rm.data) ||
                   (rm.fu && o_mau_rdata !== 32'd0) ||
                   (!rm.fu && o_fu_rdata !== 32'd0)) begin
                  errors++;
                  $display("FAIL rsp actual fu_rv=%0b mau_rv=%0b fu_d=%h mau_d=%h required fu=%0b data=%h",
                           o_fu_rvalid, o_mau_rvalid, o_fu_rdata,
                           o_mau_rdata, rm.fu, rm.data);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_req"},    32'(o_mem_req),    32'd0);
      chk({nm, "_we"},     32'(o_mem_we),     32'd0);
      chk({nm, "_addr"},   o_mem_addr,        32'd0);
      chk({nm, "_wdata"},  o_mem_wdata,       32'd0);
      chk({nm, "_len"},    32'(o_mem_len),    32'd0);
      chk({nm, "_gnts"},   32'({o_fu_gnt, o_mau_gnt}), 32'd0);
      chk({nm, "_rvs"},    32'({o_fu_rvalid, o_mau_rvalid}), 32'd0);
      chk({nm, "_fu_rd"},  o_fu_rdata,        32'd0);
      chk({nm, "_mau_rd"}, o_mau_rdata,       32'd0);
   endtask

   task automatic push_g(input logic fu, input logic we,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] len);
      gexp_t g;
      g.fu = fu; g.we = we; g.addr = a; g.wdata = wd; g.len = len;
      gq.push_back(g);
   endtask

   task automatic push_r(input logic fu, input logic cd,
                         input logic [31:0] d);
      rexp_t r;
      r.fu = fu; r.chk_data = cd; r.data = d;
      rq.push_back(r);
   endtask

   task automatic fu_issue(input logic [31:0] a);
      bit got;
      got = 1'b0;
      i_fu_req  = 1'b1;
      i_fu_addr = a;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (o_fu_gnt) begin
            got = 1'b1;
            break;
         end
      end
      chk("fu_gnt_seen", 32'(got), 32'd1);
      tick();
      i_fu_req  = 1'b0;
      i_fu_addr = '0;
   endtask

   task automatic mau_issue(input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] len);
      bit got;
      got = 1'b0;
      i_mau_req = 1'b1; i_mau_we = we;
      i_mau_addr = a; i_mau_wdata = wd; i_mau_len = len;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (o_mau_gnt) begin
            got = 1'b1;
            break;
         end
      end
      chk("mau_gnt_seen", 32'(got), 32'd1);
      tick();
      i_mau_req = 1'b0; i_mau_we = 1'b0;
      i_mau_addr = '0; i_mau_wdata = '0; i_mau_len = '0;
   endtask

   task automatic drain(input string nm);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (gq.size() == 0 && rq.size() == 0 && !pend && !i_mem_rvalid) begin
            done = 1'b1;
            break;
         end
      end
      chk({nm, "_drained"}, 32'(done), 32'd1);
      repeat (3) tick();
   endtask

   int g0, g1, r0, base;

   initial begin
      #200000;
      $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      i_fu_req = 1'b0; i_fu_addr = '0; i_fu_flush = 1'b0;
      i_mau_req = 1'b0; i_mau_we = 1'b0; i_mau_addr = '0;
      i_mau_wdata = '0; i_mau_len = '0; i_mem_gnt = 1'b1;
      mem[32'h100] = 32'hDEADBEEF;
      mem[32'h104] = 32'h0BADF00D;
      mem[32'h400] = 32'h12345678;
      mem[32'h500] = 32'hF00D0500;
      mem[32'h600] = 32'hCAFE0600;
      mem[32'h700] = 32'h77007700;
      mem[32'h704] = 32'h70470470;
      mem[32'h804] = 32'h80480480;

      // Reset with both requesters active: everything must stay quiet.
      i_fu_req = 1'b1; i_fu_addr = 32'h100;
      i_mau_req = 1'b1; i_mau_we = 1'b1; i_mau_addr = 32'h200;
      i_mau_wdata = 32'h55; i_mau_len = 2'd2;
      @(negedge clk);
      chk_zero("rst0");
      i_fu_req = 1'b0; i_fu_addr = '0;
      i_mau_req = 1'b0; i_mau_we = 1'b0; i_mau_addr = '0;
      i_mau_wdata = '0; i_mau_len = '0;
      tick();
      rstn = 1'b1;
      repeat (2) tick();

      // FU only, 0-cycle grant, response two cycles later, back to back.
      lat = 2;
      push_g(1'b1, 1'b0, 32'h100, 32'h0, 2'd2);
      push_r(1'b1, 1'b1, 32'hDEADBEEF);
      push_g(1'b1, 1'b0, 32'h104, 32'h0, 2'd2);
      push_r(1'b1, 1'b1, 32'h0BADF00D);
      fu_issue(32'h100);
      g0 = last_gnt_cyc;
      fu_issue(32'h104);
      g1 = last_gnt_cyc;
      r0 = last_rsp_cyc;
      chk("fu_rsp_latency", 32'(r0 - g0), 32'd2);
      chk("fu_issue_spacing", 32'(g1 - g0), 32'd3);
      drain("t1");

      // Same-cycle FU and MAU: MAU byte store first, FU then reads it.
      push_g(1'b0, 1'b1, 32'h200, 32'h55, 2'd0);
      push_r(1'b0, 1'b0, 32'h0);
      push_g(1'b1, 1'b0, 32'h200, 32'h0, 2'd2);
      push_r(1'b1, 1'b1, 32'h00000055);
      fork
         mau_issue(1'b1, 32'h200, 32'h55, 2'd0);
         fu_issue(32'h200);
      join
      drain("t2");

      // Starvation guard: MAU x4, FU, MAU x4, FU.
      lat = 1;
      for (int k = 0; k < 2; k++) begin
         for (int m = 0; m < 4; m++) begin
            push_g(1'b0, 1'b0, 32'h600, 32'h0, 2'd2);
            push_r(1'b0, 1'b1, 32'hCAFE0600);
         end
         push_g(1'b1, 1'b0, 32'h500, 32'h0, 2'd2);
         push_r(1'b1, 1'b1, 32'hF00D0500);
      end
      base = gnt_seen;
      i_fu_req = 1'b1; i_fu_addr = 32'h500;
      i_mau_req = 1'b1; i_mau_we = 1'b0; i_mau_addr = 32'h600;
      i_mau_len = 2'd2;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (gnt_seen >= base + 10) break;
      end
      i_fu_req = 1'b0; i_fu_addr = '0;
      i_mau_req = 1'b0; i_mau_addr = '0; i_mau_len = '0;
      chk("starve_grants", 32'(gnt_seen - base), 32'd10);
      drain("t3");

      // Flush during WAIT drops the FU response.
      lat = 3;
      push_g(1'b1, 1'b0, 32'h300, 32'h0, 2'd2);
      fu_issue(32'h300);
      i_fu_flush = 1'b1;
      tick();
      i_fu_flush = 1'b0;
      drain("t4a");

      // Flush in the very cycle of the response also drops it.
      lat = 2;
      push_g(1'b1, 1'b0, 32'h304, 32'h0, 2'd2);
      fu_issue(32'h304);
      tick();
      i_fu_flush = 1'b1;
      tick();
      i_fu_flush = 1'b0;
      drain("t4b");

      push_g(1'b1, 1'b0, 32'h400, 32'h0, 2'd2);
      push_r(1'b1, 1'b1, 32'h12345678);
      fu_issue(32'h400);
      drain("t4c");

      // HOLD: memory stalls three cycles, FU arrives, no re-arbitration.
      i_mem_gnt = 1'b0;
      push_g(1'b0, 1'b0, 32'h700, 32'h0, 2'd2);
      push_r(1'b0, 1'b1, 32'h77007700);
      push_g(1'b1, 1'b0, 32'h704, 32'h0, 2'd2);
      push_r(1'b1, 1'b1, 32'h70470470);
      fork
         mau_issue(1'b0, 32'h700, 32'h0, 2'd2);
         begin
            tick();
            fu_issue(32'h704);
         end
         begin
            repeat (3) begin
               @(negedge clk);
               chk("hold_req", 32'(o_mem_req), 32'd1);
               chk("hold_addr", o_mem_addr, 32'h700);
            end
            tick();
            i_mem_gnt = 1'b1;
         end
      join
      drain("t5");

      // Reset in the middle of WAIT with FU still requesting.
      lat = 5;
      push_g(1'b1, 1'b0, 32'h800, 32'h0, 2'd2);
      fu_issue(32'h800);
      i_fu_req = 1'b1; i_fu_addr = 32'h804;
      rstn = 1'b0;
      @(negedge clk);
      chk_zero("rst1");
      tick();
      @(negedge clk);
      chk("rst1_req_late", 32'(o_mem_req), 32'd0);
      chk("rst1_fu_rv_late", 32'(o_fu_rvalid), 32'd0);
      tick();
      lat = 2;
      push_g(1'b1, 1'b0, 32'h804, 32'h0, 2'd2);
      push_r(1'b1, 1'b1, 32'h80480480);
      rstn = 1'b1;
      fu_issue(32'h804);
      drain("t6");

      chk("gq_empty", 32'(gq.size()), 32'd0);
      chk("rq_empty", 32'(rq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
